// File: rtl/obuft_arb_pkg.sv
// Shared types for the OBUFT bus arbiter: FSM state encoding and counter widths.
package obuft_arb_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, PARK} arb_state_t;

  // Counters are sized for TURN_CYC and MAX_HOLD values up to 256.
  localparam int TURN_CNT_W = 8;
  localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/obuft_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Zero latency, no flow control; pick_vld low when no request is set.
module obuft_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [IDX_W-1:0] k;
  int               sum;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    k        = '0;
    sum      = 0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      k = IDX_W'(sum);
      if (req[k]) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_idx   = k;
        pick_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obuft_bus_arbiter.sv
// Round-robin owner sequencing for a shared tri-state pad bus with high-Z turnaround between tenures.
// Grant 1 cycle after request, data path combinational; no backpressure. OBUFT_ARB_PARK_EN enables parking.
module obuft_bus_arbiter
  import obuft_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   gts_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       bus_i,
  output logic [WIDTH-1:0]       bus_t,
  output logic [IDX_W-1:0]       bus_own
);

  arb_state_t            state_q, state_d;
  logic [N_REQ-1:0]      gnt_q;
  logic [IDX_W-1:0]      own_q, ptr_q;
  logic [HOLD_CNT_W-1:0] hold_q;
  logic [TURN_CNT_W-1:0] turn_q;

  logic [N_REQ-1:0]      req_elig, pick_oh, own_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld, contender, hold_max, turn_end, leave, drive;
  logic [WIDTH-1:0]      data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign data_arr[g] = data_in[g*WIDTH +: WIDTH];
  end

  // Global tristate suppresses all new grants.
  assign req_elig  = gts_in ? '0 : req;
  assign own_oh    = N_REQ'(1) << own_q;
  assign contender = |(req & ~own_oh);
  assign hold_max  = (hold_q == HOLD_CNT_W'(MAX_HOLD - 1));
  assign turn_end  = (turn_q == TURN_CNT_W'(TURN_CYC - 1));
  assign leave     = !req[own_q] || gts_in || (hold_max && contender);

  obuft_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req_elig),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == DRIVE && state_q != DRIVE) begin
        own_q  <= pick_idx;
        gnt_q  <= pick_oh;
        hold_q <= '0;
      end else if (state_q == DRIVE && state_d != DRIVE) begin
        gnt_q <= '0;
        ptr_q <= (own_q == IDX_W'(N_REQ - 1)) ? '0 : own_q + 1'b1;
      end else if (state_q == DRIVE && !hold_max) begin
        hold_q <= hold_q + 1'b1;
      end
      if (state_d == TURN) begin
        turn_q <= (state_q == TURN) ? turn_q + 1'b1 : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pick_vld) state_d = DRIVE;
      DRIVE: begin
        if (leave) begin
`ifdef OBUFT_ARB_PARK_EN
          state_d = (!gts_in && req == '0) ? PARK : TURN;
`else
          state_d = TURN;
`endif
        end
      end
      TURN:  if (turn_end) state_d = pick_vld ? DRIVE : IDLE;
      PARK: begin
`ifdef OBUFT_ARB_PARK_EN
        // A different requester must still see a turnaround before driving.
        if (gts_in)        state_d = IDLE;
        else if (pick_vld) state_d = (pick_idx == own_q) ? DRIVE : TURN;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef OBUFT_ARB_PARK_EN
    drive = (state_q == DRIVE) || (state_q == PARK);
`else
    drive = (state_q == DRIVE);
`endif
    gnt     = gnt_q;
    bus_own = own_q;
    bus_t   = (drive && !gts_in) ? '0 : '1;
    bus_i   = (state_q == DRIVE) ? data_arr[own_q] : '0;
  end

endmodule

// File: tb/tb_obuft_bus_arbiter.sv
// Scoreboard bench for obuft_bus_arbiter (TURN_CYC=2, MAX_HOLD=4): per-cycle expected
// {gnt, bus_t, bus_i, bus_own} pushed when inputs are driven, popped at the falling edge.
module tb_obuft_bus_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           gts_in = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   bus_i, bus_t;
  logic [1:0]     bus_own;

  int n_cmp = 0;
  int n_bad = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  obuft_bus_arbiter #(.N_REQ(N), .WIDTH(W), .TURN_CYC(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gts_in(gts_in),
    .gnt(gnt), .bus_i(bus_i), .bus_t(bus_t), .bus_own(bus_own)
  );

  function automatic logic [21:0] ew(input logic [3:0] g, input logic drv,
                                     input logic [7:0] i, input logic [1:0] o);
    return {g, drv ? 8'h00 : 8'hFF, i, o};
  endfunction

  function automatic logic [7:0] dslice(input int k);
    return 8'(8'hA0 + k * 17);
  endfunction

  task automatic quiet_reset();
    rst_n = 1'b0; req = '0; gts_in = 1'b0;
    for (int k = 0; k < N; k++) data_in[k*W +: W] = dslice(k);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [21:0] got, e;
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
    @(negedge clk);
    got = {gnt, bus_t, bus_i, bus_own};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset: got %h want %h", got, e); end
  endtask

  task automatic test_single();
    logic [21:0] got, e;
    quiet_reset();
    for (int c = 0; c <= 8; c++) begin
      req = (c <= 4) ? 4'b0100 : 4'b0000;
      data_in[2*W +: W] = 8'(8'h10 + c);
      if (c == 0)      exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (c <= 5) exp_q.push_back(ew(4'b0100, 1'b1, 8'(8'h10 + c), 2'd2));
      else             exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd2));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL single c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [21:0] got, e;
    int p, k;
    quiet_reset();
    for (int c = 0; c <= 28; c++) begin
      req = 4'b1111;
      p = (c - 1) % 6;
      k = ((c - 1) / 6) % 4;
      if (c == 0)     exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (p < 4) exp_q.push_back(ew(4'(1 << k), 1'b1, dslice(k), 2'(k)));
      else            exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'(k)));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL rr c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gts();
    logic [21:0] got, e;
    quiet_reset();
    for (int c = 0; c <= 9; c++) begin
      req = 4'b0010;
      gts_in = (c >= 3 && c <= 6);
      if (c == 0)                 exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (c <= 2 || c >= 8)  exp_q.push_back(ew(4'b0010, 1'b1, dslice(1), 2'd1));
      else if (c == 3)            exp_q.push_back(ew(4'b0010, 1'b0, dslice(1), 2'd1));
      else                        exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd1));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL gts c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
    gts_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [21:0] got, e;
    quiet_reset();
    for (int c = 0; c <= 5; c++) begin
      rst_n = (c != 3);
      req = (c >= 4) ? 4'b0111 : 4'b0110;
      if (c == 0)      exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (c <= 3) exp_q.push_back(ew(4'b0010, 1'b1, dslice(1), 2'd1));
      else if (c == 4) exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else             exp_q.push_back(ew(4'b0001, 1'b1, dslice(0), 2'd0));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL rst_mid c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drop_expire();
    logic [21:0] got, e;
    quiet_reset();
    for (int c = 0; c <= 8; c++) begin
      req = (c <= 3) ? 4'b1001 : 4'b1000;
      if (c == 0)      exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (c <= 4) exp_q.push_back(ew(4'b0001, 1'b1, dslice(0), 2'd0));
      else if (c <= 6) exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else             exp_q.push_back(ew(4'b1000, 1'b1, dslice(3), 2'd3));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL drop_expire c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
  endtask

`ifdef OBUFT_ARB_PARK_EN
  task automatic test_park();
    logic [21:0] got, e;
    quiet_reset();
    for (int c = 0; c <= 6; c++) begin
      req = (c <= 2 || c >= 5) ? 4'b0010 : 4'b0000;
      if (c == 0)                exp_q.push_back(ew(4'b0000, 1'b0, 8'h00, 2'd0));
      else if (c <= 3 || c == 6) exp_q.push_back(ew(4'b0010, 1'b1, dslice(1), 2'd1));
      else                       exp_q.push_back(ew(4'b0000, 1'b1, 8'h00, 2'd1));
      @(negedge clk);
      got = {gnt, bus_t, bus_i, bus_own};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL park c%0d: got %h want %h", c, got, e); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gts();
    test_reset_mid();
    test_drop_expire();
`ifdef OBUFT_ARB_PARK_EN
    test_park();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
